counter_monitor: RTL

Passive checker sitting on the opposite end of the up/down/loadable counter interface: it observes the control inputs (`en`, `dn`, `load`, `data`) driven into a counter and the `count` it returns. Each cycle it predicts the next count, compares it with the observed value, and reports mismatches, wrap events and a saturating error tally. It is instantiated beside any counter instance, in simulation or on silicon, as a self-check.

---
 rtl/counter_monitor_if.sv | 21 ++
 rtl/counter_monitor.sv | 139 +++++++++++++
 2 files changed

// File: rtl/counter_monitor_if.sv
// counter_monitor_if
// Bundles the signals of an up/down/loadable counter as seen from outside it.
// The master modport drives the counter controls and its count. The slave
// modport observes all of them and is used by counter_monitor.
//   en    : counter enable
//   dn    : direction, 1 = down, 0 = up
//   load  : load strobe, has priority over en
//   data  : load value (WIDTH)
//   count : counter output (WIDTH)
interface counter_monitor_if #(
   parameter int WIDTH = 4
);
   logic             en;
   logic             dn;
   logic             load;
   logic [WIDTH-1:0] data;
   logic [WIDTH-1:0] count;

   modport master (output en, dn, load, data, count);
   modport slave  (input  en, dn, load, data, count);
endinterface

// File: rtl/counter_monitor.sv
// counter_monitor
// Passive checker placed beside an up/down/loadable counter. Every edge it
// captures the counter controls and count. From the previous capture it
// predicts the count for this edge, compares it with the observed count, and
// reports mismatches, correct wrap steps and a saturating error tally.
// Optional feature macro: COUNTER_MON_HALT_EN. When defined, the first
// mismatch parks the monitor in FAULT until rst. When undefined, the FAULT
// state is not built and fault is tied to 0.
// Ports:
//   clk       : rising-edge clock, the same clock as the observed counter
//   rst       : synchronous active-high reset
//   bus       : counter_monitor_if.slave (en, dn, load, data, count)
//   valid     : 1 while tracking
//   exp_count : registered prediction of count
//   mismatch  : one-cycle pulse when the observed count differs from the prediction
//   wrap      : one-cycle pulse on a correct max->0 or 0->max step
//   fault     : 1 while halted (only with COUNTER_MON_HALT_EN)
//   err_cnt   : saturating mismatch count since reset
module counter_monitor #(
   parameter int WIDTH = 4,
   parameter int ECW   = 8
) (
   input  logic             clk,
   input  logic             rst,
   counter_monitor_if.slave bus,
   output logic             valid,
   output logic [WIDTH-1:0] exp_count,
   output logic             mismatch,
   output logic             wrap,
   output logic             fault,
   output logic [ECW-1:0]   err_cnt
);

`ifdef COUNTER_MON_HALT_EN
   typedef enum logic [1:0] {st_idle = 2'd0, st_track = 2'd1, st_fault = 2'd2} state_t;
`else
   typedef enum logic {st_idle = 1'b0, st_track = 1'b1} state_t;
`endif

   state_t state, state_nx;

   logic             en_p0, dn_p0, load_p0;
   logic [WIDTH-1:0] data_p0, cnt_p0;
   logic [WIDTH-1:0] pred;
   logic             miss, wrap_hit, cmp_en;

   function automatic logic [WIDTH-1:0] predict(
      input logic [WIDTH-1:0] cnt,
      input logic             en_i,
      input logic             dn_i,
      input logic             load_i,
      input logic [WIDTH-1:0] data_i
   );
      if (load_i)
         return data_i;
      else if (en_i && !dn_i)
         return cnt + WIDTH'(1);
      else if (en_i && dn_i)
         return cnt - WIDTH'(1);
      else
         return cnt;
   endfunction

   function automatic logic [ECW-1:0] sat_inc(input logic [ECW-1:0] e);
      return (e == {ECW{1'b1}}) ? e : e + ECW'(1);
   endfunction

   // Stage p0: unconditional capture of the observed bus. These are data-only
   // registers; the FSM guarantees no compare happens before they are loaded.
   always_ff @(posedge clk) begin
      en_p0   <= bus.en;
      dn_p0   <= bus.dn;
      load_p0 <= bus.load;
      data_p0 <= bus.data;
      cnt_p0  <= bus.count;
   end

   assign pred = predict(cnt_p0, en_p0, dn_p0, load_p0, data_p0);
   assign miss = (bus.count != pred);

   // A load of 0 or all-ones is never a wrap, so the step must be a pure count.
   assign wrap_hit = !miss && en_p0 && !load_p0 &&
                     ((!dn_p0 && (cnt_p0 == {WIDTH{1'b1}})) ||
                      ( dn_p0 && (cnt_p0 == {WIDTH{1'b0}})));

   always_ff @(posedge clk) begin
      if (rst)
         state <= st_idle;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      cmp_en   = 1'b0;
      case (state)
         st_idle:  state_nx = st_track;
         st_track: begin
            cmp_en = 1'b1;
`ifdef COUNTER_MON_HALT_EN
            if (miss)
               state_nx = st_fault;
`endif
         end
`ifdef COUNTER_MON_HALT_EN
         st_fault: state_nx = st_fault;
`endif
         default:  state_nx = st_idle;
      endcase
   end

   // Stage p1: compare results. Outside tracking the pulses are forced low and
   // exp_count/err_cnt hold, which freezes err_cnt at its FAULT entry value.
   always_ff @(posedge clk) begin
      if (rst) begin
         mismatch  <= 1'b0;
         wrap      <= 1'b0;
         exp_count <= '0;
         err_cnt   <= '0;
      end else if (cmp_en) begin
         mismatch  <= miss;
         wrap      <= wrap_hit;
         exp_count <= pred;
         if (miss)
            err_cnt <= sat_inc(err_cnt);
      end else begin
         mismatch  <= 1'b0;
         wrap      <= 1'b0;
      end
   end

   assign valid = (state == st_track);
`ifdef COUNTER_MON_HALT_EN
   assign fault = (state == st_fault);
`else
   assign fault = 1'b0;
`endif

endmodule
